// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush/bubble control and divide freeze for the 5-stage core
module pipeline_stall_controller #(
    parameter int MAX_MULDIV_CYCLES = 40,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken_ex,
    input  logic             muldiv_req_ex,
    input  logic             muldiv_done,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             muldiv_start,
    output logic             md_busy,
    output logic             muldiv_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BW = (MAX_MULDIV_CYCLES > 1) ? $clog2(MAX_MULDIV_CYCLES) : 1;
    localparam logic [BW-1:0]    BUSY_LAST = BW'(MAX_MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t          state;
    logic [BW-1:0]   busy_cnt;
    logic            release_md;
    logic            timeout_hit;

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        muldiv_start = 1'b0;
        md_busy      = 1'b0;
        release_md   = 1'b0;
        timeout_hit  = 1'b0;
        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (muldiv_req_ex) begin
                        muldiv_start = 1'b1;
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (branch_taken_ex) begin
                        // the dependent instruction is flushed, so load-use is moot
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_stall) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy     = 1'b1;
                    release_md  = muldiv_done || (busy_cnt == BUSY_LAST);
                    // a done coinciding with the watchdog counts as a normal completion
                    timeout_hit = !muldiv_done && (busy_cnt == BUSY_LAST);
                    if (!release_md) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                    id_ex_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            busy_cnt       <= '0;
            muldiv_timeout <= 1'b0;
            stall_count    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (muldiv_req_ex) begin
                        state    <= MD_BUSY;
                        busy_cnt <= '0;
                    end
                end
                MD_BUSY: begin
                    if (release_md) begin
                        state <= RUN;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
            if (timeout_hit) begin
                muldiv_timeout <= 1'b1;
            end
            if (!pc_we && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed and randomized checks against a cycle-level reference model
module tb_pipeline_stall_controller;

    localparam int MAXC = 8;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_use_stall = 1'b0;
    logic          branch_taken_ex = 1'b0;
    logic          muldiv_req_ex = 1'b0;
    logic          muldiv_done = 1'b0;
    logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush;
    logic          muldiv_start, md_busy, muldiv_timeout;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // reference model: in-divide flag, ordinal of the current MD_BUSY cycle, sticky flag, stall total
    bit m_busy;
    int m_k;
    bit m_to;
    int m_stall;

    pipeline_stall_controller #(.MAX_MULDIV_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
        .muldiv_req_ex(muldiv_req_ex), .muldiv_done(muldiv_done),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .muldiv_start(muldiv_start), .md_busy(md_busy),
        .muldiv_timeout(muldiv_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start, md_busy};
    endfunction

    // entered at posedge+1; leaves at the following posedge+1
    task automatic step(input logic r, input logic b, input logic l, input logic d);
        logic [7:0] e;
        bit rel;
        bit to;
        muldiv_req_ex   = r;
        branch_taken_ex = b;
        load_use_stall  = l;
        muldiv_done     = d;
        rel = 1'b0;
        to  = 1'b0;
        if (!m_busy) begin
            if (r)      e = 8'b000_001_1_0;
            else if (b) e = 8'b111_110_0_0;
            else if (l) e = 8'b001_010_0_0;
            else        e = 8'b111_000_0_0;
        end else begin
            rel = d || (m_k == MAXC);
            to  = !d && (m_k == MAXC);
            e   = rel ? 8'b111_000_0_1 : 8'b000_001_0_1;
        end
        @(negedge clk);
        check("ctl", {24'd0, ctl_vec()}, {24'd0, e});
        check("stall_count", {28'd0, stall_count}, m_stall);
        check("timeout", {31'd0, muldiv_timeout}, {31'd0, m_to});
        @(posedge clk);
        #1;
        if (m_busy) begin
            if (rel) m_busy = 1'b0;
            else     m_k++;
        end else if (r) begin
            m_busy = 1'b1;
            m_k    = 1;
        end
        if (to) m_to = 1'b1;
        if (!e[7] && m_stall < SAT) m_stall++;
    endtask

    // entered at posedge+1; asserts reset between edges to exercise its asynchronous effect
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ctl", {24'd0, ctl_vec()}, {24'd0, 8'b000_111_0_0});
        check("rst_stall", {28'd0, stall_count}, 32'd0);
        check("rst_timeout", {31'd0, muldiv_timeout}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_ctl", {24'd0, ctl_vec()}, {24'd0, 8'b000_111_0_0});
        rst = 1'b0;
        muldiv_req_ex = 1'b0;
        branch_taken_ex = 1'b0;
        load_use_stall = 1'b0;
        muldiv_done = 1'b0;
        m_busy  = 1'b0;
        m_k     = 0;
        m_to    = 1'b0;
        m_stall = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("lu_count", {28'd0, stall_count}, 32'd1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        check("br_lu_count", {28'd0, stall_count}, 32'd1);

        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("div_count", {28'd0, stall_count}, 32'd6);

        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < MAXC; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("to_flag", {31'd0, muldiv_timeout}, 32'd1);
        check("to_count", {28'd0, stall_count}, 32'd8);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);

        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("post_rst_count", {28'd0, stall_count}, 32'd0);

        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        check("sat_count", {28'd0, stall_count}, SAT);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central pipeline-control responder for the rv32im 5-stage core. It consumes the load-use stall request from hazard detection, the EX-stage branch-taken flush request, and the multi-cycle divide request with its done handshake. It drives the pipeline-register write enables and bubble/flush controls, plus a stall-cycle performance counter.

Parameters:
MAX_MULDIV_CYCLES, 40, watchdog limit in cycles for one divide operation.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
load_use_stall  input  1  load-use hazard request from hazard detection (combinational, ID vs ID/EX).
branch_taken_ex  input  1  taken branch or jump resolved in EX.
muldiv_req_ex  input  1  ID/EX holds a multi-cycle DIV/DIVU/REM/REMU.
muldiv_done  input  1  divider result valid, single-cycle pulse.
pc_we  output  1  PC register write enable.
if_id_we  output  1  IF/ID write enable.
if_id_flush  output  1  IF/ID loads a NOP on this edge.
id_ex_we  output  1  ID/EX write enable.
id_ex_flush  output  1  ID/EX loads a bubble on this edge.
ex_mem_flush  output  1  EX/MEM loads a bubble on this edge.
muldiv_start  output  1  one-cycle start pulse to the divider.
md_busy  output  1  high while the FSM is in MD_BUSY.
muldiv_timeout  output  1  sticky error flag; set when the watchdog expires.
stall_count  output  CNT_W  saturating count of cycles with pc_we==0.

Behaviour:
- Reset (rst=1, asynchronous): state=RUN; busy counter=0; muldiv_timeout=0; stall_count=0.
- While rst is held: pc_we=if_id_we=id_ex_we=0, if_id_flush=id_ex_flush=ex_mem_flush=1, muldiv_start=0, md_busy=0.
- Control outputs are combinational from state and inputs. Registers update on the clk rising edge.
- States: RUN, MD_BUSY.
- RUN, input priority: muldiv_req_ex > branch_taken_ex > load_use_stall.
  - muldiv_req_ex=1: muldiv_start=1; pc_we=if_id_we=id_ex_we=0; ex_mem_flush=1; next state MD_BUSY; busy counter cleared to 0.
  - Else branch_taken_ex=1: pc_we=if_id_we=id_ex_we=1; if_id_flush=id_ex_flush=1. Two bubbles; load_use_stall is ignored because the dependent instruction is flushed.
  - Else load_use_stall=1: pc_we=if_id_we=0; id_ex_we=1; id_ex_flush=1. One bubble; the load advances.
  - Else: all enables=1, all flushes=0.
  - muldiv_done in RUN is spurious and ignored.
- MD_BUSY:
  - Freeze: pc_we=if_id_we=id_ex_we=0; ex_mem_flush=1; muldiv_start=0; md_busy=1.
  - load_use_stall and branch_taken_ex are ignored.
  - Busy counter increments every cycle.
- Release from MD_BUSY:
  - Triggered by muldiv_done=1, or by the busy counter reaching MAX_MULDIV_CYCLES-1.
  - In that same cycle: all enables=1, ex_mem_flush=0, so the result enters EX/MEM and the next instruction enters ID/EX. Next state RUN.
  - On a timeout release, muldiv_timeout is set and stays set until reset.
  - If done and timeout coincide, the release is treated as done; the flag is not set.
- Back-to-back divides: the second divide is detected in the first RUN cycle after release (muldiv_req_ex now reflects the new ID/EX content). It gets a fresh start pulse.
- stall_count increments on every edge where pc_we==0 (including the MD_BUSY and load-use cycles) and saturates at 2^CNT_W-1.
- Reset mid-divide: the FSM returns to RUN immediately. No start pulse is issued until a new muldiv_req_ex is seen after reset deasserts.

Test Plan:
- Load-use: RUN, load_use_stall=1 for 1 cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all enables 1; stall_count=1.
- Branch+load-use same cycle: branch_taken_ex=1, load_use_stall=1 -> pc_we=1, if_id_flush=1, id_ex_flush=1; stall_count unchanged.
- Divide, done after 5 cycles:
  - muldiv_req_ex=1 -> muldiv_start pulses exactly once.
  - md_busy=1 for 5 cycles, then muldiv_done -> release cycle with all we=1.
  - stall_count=6.
- Timeout: MAX_MULDIV_CYCLES=8, muldiv_done never asserts -> release after the start cycle plus 8 MD_BUSY cycles; muldiv_timeout=1 and stays 1 until rst.
- Reset mid-divide: rst asserted 2 cycles into MD_BUSY -> md_busy=0 asynchronously; after release with muldiv_req_ex=0, no muldiv_start; stall_count=0.
- Saturation: CNT_W=4, hold load_use_stall=1 for 20 cycles -> stall_count stops at 15.
